// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// Load/store unit for the MEM stage of the 5-stage RV32I pipeline. It takes the
// EX-stage effective address, store operand and funct3, and turns them into one
// byte-lane access on a req/gnt/rvalid data-memory bus. While the access is in
// flight it stalls the pipeline. Loads are aligned and sign- or zero-extended
// before they are handed to MEM2WB.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   valid_i            MEM-stage instruction is valid
//   mem_read_c_i       instruction is a load
//   mem_write_c_i      instruction is a store (takes priority over load)
//   funct3_i           [1:0] size (00 byte, 01 half, 1x word), [2] unsigned load
//   addr_i             effective byte address
//   store_data_i       rs2 value
//   stall_o            freeze the earlier pipeline stages
//   mem_read_data_o    formatted load result (held between loads)
//   misaligned_o       current access is misaligned; no bus access is made
//   dmem_*_o           request side of the data-memory bus
//   dmem_gnt_i         request accepted
//   dmem_rvalid_i      read data valid
//   dmem_rdata_i       read word
module mem_stage_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              mem_read_c_i,
    input  logic              mem_write_c_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       store_data_i,
    output logic              stall_o,
    output logic [31:0]       mem_read_data_o,
    output logic              misaligned_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              mem_op;
    logic              misaligned;
    logic              access;
    logic [3:0]        be_calc;
    logic [31:0]       wdata_calc;
    logic [31:0]       lane;
    logic [31:0]       load_fmt;

    // Decode of the incoming instruction. Only used while IDLE; in every other
    // state the latched copy drives the bus.
    always_comb begin
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                misaligned = 1'b0;
                be_calc    = 4'b0001 << addr_i[1:0];
                wdata_calc = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                misaligned = addr_i[0];
                be_calc    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{store_data_i[15:0]}};
            end
            default: begin
                misaligned = |addr_i[1:0];
                be_calc    = 4'b1111;
                wdata_calc = store_data_i;
            end
        endcase
    end

    assign mem_op = mem_read_c_i | mem_write_c_i;
    assign access = valid_i & mem_op & ~misaligned;

    // Load formatting works on the latched address/funct3 so it stays correct
    // however long the response takes.
    assign lane = dmem_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_fmt = dmem_rdata_i;
        case (funct3_q[1:0])
            2'b00:   load_fmt = {{24{~funct3_q[2] & lane[7]}}, lane[7:0]};
            2'b01:   load_fmt = {{16{~funct3_q[2] & lane[15]}}, lane[15:0]};
            default: load_fmt = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    addr_d   = addr_i;
                    funct3_d = funct3_i;
                    we_d     = mem_write_c_i;
                    be_d     = be_calc;
                    wdata_d  = wdata_calc;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // An rvalid in the grant cycle is not ours yet; the bus only
                // returns data from the following cycle on.
                if (dmem_gnt_i) begin
                    state_d = we_q ? DONE : RESP;
                end
            end
            RESP: begin
                if (dmem_rvalid_i) begin
                    rdata_d = load_fmt;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Bus outputs come only from flops, and are gated to zero outside REQ so
    // the memory never sees stale enables.
    assign dmem_req_o      = (state_q == REQ);
    assign dmem_we_o       = (state_q == REQ) & we_q;
    assign dmem_be_o       = (state_q == REQ) ? be_q : 4'b0000;
    assign dmem_wdata_o    = (state_q == REQ) ? wdata_q : 32'h0;
    assign dmem_addr_o     = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_read_data_o = rdata_q;

    // The IDLE term lets the stall begin in the same cycle the access shows up.
    assign stall_o      = ((state_q == IDLE) & access) | (state_q == REQ) | (state_q == RESP);
    assign misaligned_o = (state_q == IDLE) & valid_i & mem_op & misaligned;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
// Self-checking bench for mem_stage_lsu. The driver walks each instruction
// through a timeline computed from its grant/data delays and publishes the
// expected outputs for every cycle; one compare process checks them on the
// falling edge. A few hand-computed literals pin the model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        mem_read_c_i;
    logic        mem_write_c_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic        stall_o;
    logic [31:0] mem_read_data_o;
    logic        misaligned_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    mem_stage_lsu #(.ADDR_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_i         (valid_i),
        .mem_read_c_i    (mem_read_c_i),
        .mem_write_c_i   (mem_write_c_i),
        .funct3_i        (funct3_i),
        .addr_i          (addr_i),
        .store_data_i    (store_data_i),
        .stall_o         (stall_o),
        .mem_read_data_o (mem_read_data_o),
        .misaligned_o    (misaligned_o),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_be_o       (dmem_be_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_gnt_i      (dmem_gnt_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .dmem_rdata_i    (dmem_rdata_i)
    );

    always #5 clk = ~clk;

    // Counters and snapshots owned by the compare process.
    int          testsRun = 0;
    int          testsFailed = 0;
    int          stallTotal = 0;
    logic [3:0]  snapBe = '0;
    logic [31:0] snapWdata = '0;
    logic [31:0] snapAddr = '0;
    logic        snapWe = 1'b0;
    int          litSeen = 0;

    // Expectations published by the driver.
    logic        checkEn = 1'b0;
    logic        expStall, expMis, expReq, expWe;
    logic [3:0]  expBe;
    logic [31:0] expWdata, expAddr, expRd;
    int          stallBase = 0;

    // Literal checks posted by the driver, evaluated by the compare process.
    string       litName [16];
    int          litSel  [16];
    logic [31:0] litExp  [16];
    int          litN = 0;
    int          litGen = 0;

    // ---------------- reference model ----------------
    function automatic int sizeBytes(logic [2:0] f3);
        if (f3[1]) return 4;
        if (f3[0]) return 2;
        return 1;
    endfunction

    function automatic logic modelMis(logic [2:0] f3, logic [31:0] a);
        return (int'(a[1:0]) % sizeBytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] modelBe(logic [2:0] f3, logic [31:0] a);
        logic [3:0] be;
        int bytes, start;
        bytes = sizeBytes(f3);
        start = int'(a[1:0]) - (int'(a[1:0]) % bytes);
        for (int i = 0; i < 4; i++) be[i] = (i >= start) && (i < start + bytes);
        return be;
    endfunction

    function automatic logic [31:0] modelWdata(logic [2:0] f3, logic [31:0] sd);
        logic [31:0] w;
        int bytes;
        bytes = sizeBytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % bytes) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] modelLoad(logic [2:0] f3, logic [31:0] a, logic [31:0] word);
        longint lane, lim;
        int bytes, off;
        bytes = sizeBytes(f3);
        off   = int'(a[1:0]);
        if (bytes == 4) return word;
        lane = longint'(word >> (8 * off));
        lim  = longint'(1) << (8 * bytes);
        lane = lane % lim;
        if (!f3[2] && lane >= lim / 2) lane = lane - lim;
        return lane[31:0];
    endfunction

    // ---------------- checking ----------------
    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] litValue(int sel);
        case (sel)
            0:       return mem_read_data_o;
            1:       return {31'b0, misaligned_o};
            2:       return {31'b0, dmem_req_o};
            3:       return {31'b0, stall_o};
            4:       return {31'b0, dmem_we_o};
            5:       return {28'b0, dmem_be_o};
            6:       return dmem_wdata_o;
            7:       return dmem_addr_o;
            8:       return {28'b0, snapBe};
            9:       return snapWdata;
            10:      return snapAddr;
            11:      return {31'b0, snapWe};
            default: return 32'(stallTotal);
        endcase
    endfunction

    always @(negedge clk) begin
        if (litGen != litSeen) begin
            for (int i = 0; i < litN; i++) checkOutput(litName[i], litValue(litSel[i]), litExp[i]);
            litSeen = litGen;
        end
        if (checkEn) begin
            checkOutput("stall", {31'b0, stall_o}, {31'b0, expStall});
            checkOutput("misaligned", {31'b0, misaligned_o}, {31'b0, expMis});
            checkOutput("req", {31'b0, dmem_req_o}, {31'b0, expReq});
            checkOutput("we", {31'b0, dmem_we_o}, {31'b0, expWe});
            checkOutput("be", {28'b0, dmem_be_o}, {28'b0, expBe});
            checkOutput("wdata", dmem_wdata_o, expWdata);
            checkOutput("rdata", mem_read_data_o, expRd);
            if (expReq) checkOutput("addr", dmem_addr_o, expAddr);
        end
        if (stall_o) stallTotal++;
        if (dmem_req_o) begin
            snapBe    = dmem_be_o;
            snapWdata = dmem_wdata_o;
            snapAddr  = dmem_addr_o;
            snapWe    = dmem_we_o;
        end
    end

    // ---------------- driver ----------------
    task automatic addLit(string name, int sel, logic [31:0] e);
        litName[litN] = name;
        litSel[litN]  = sel;
        litExp[litN]  = e;
        litN++;
    endtask

    task automatic postLits();
        litGen++;
        @(negedge clk);
        #1;
        litN = 0;
    endtask

    task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd, input int gd, input int rdl,
                                 input logic forceRd, input logic [31:0] rdVal);
        logic        isMem, mis, acc, isLoad;
        logic [31:0] capt;
        int          gntK, rvK, doneK, n;
        isMem  = rd | wr;
        mis    = modelMis(f3, a);
        acc    = v & isMem & ~mis;
        isLoad = ~wr;
        gntK   = 1 + gd;
        rvK    = isLoad ? gntK + 1 + rdl : -1;
        doneK  = isLoad ? rvK + 1 : gntK + 1;
        n      = acc ? doneK + 1 : 1;
        capt   = expRd;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) stallBase = stallTotal;
            if (acc && isLoad && k == doneK) expRd = capt;
            valid_i       = v;
            mem_read_c_i  = rd;
            mem_write_c_i = wr;
            funct3_i      = f3;
            addr_i        = a;
            store_data_i  = sd;
            dmem_rdata_i  = forceRd ? rdVal : $urandom;
            dmem_gnt_i    = ($urandom_range(0, 3) == 0);
            dmem_rvalid_i = ($urandom_range(0, 3) == 0);
            expReq = acc && (k >= 1) && (k <= gntK);
            if (expReq) dmem_gnt_i = (k == gntK);
            if (acc && isLoad && k > gntK && k <= rvK) dmem_rvalid_i = (k == rvK);
            if (acc && isLoad && k == rvK) capt = modelLoad(f3, a, dmem_rdata_i);
            expStall = acc && (k < doneK);
            expMis   = v & isMem & mis;
            expWe    = expReq & wr;
            expBe    = expReq ? modelBe(f3, a) : 4'b0000;
            expWdata = expReq ? modelWdata(f3, sd) : 32'h0;
            expAddr  = a & 32'hFFFF_FFFC;
        end
        #2;
    endtask

    task automatic setIdleInputs();
        valid_i       = 1'b0;
        mem_read_c_i  = 1'b0;
        mem_write_c_i = 1'b0;
        funct3_i      = 3'b000;
        addr_i        = 32'h0;
        store_data_i  = 32'h0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        setIdleInputs();
        expRd = 32'h0;

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        addLit("rst_req", 2, 32'h0);
        addLit("rst_we", 4, 32'h0);
        addLit("rst_be", 5, 32'h0);
        addLit("rst_wdata", 6, 32'h0);
        addLit("rst_addr", 7, 32'h0);
        addLit("rst_rdata", 0, 32'h0);
        addLit("rst_stall", 3, 32'h0);
        addLit("rst_mis", 1, 32'h0);
        postLits();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset during RESP abandons the load; a late rvalid is ignored.
        @(posedge clk);
        #1;
        valid_i = 1'b1; mem_read_c_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h400;
        @(posedge clk);
        #1;
        dmem_gnt_i = 1'b1;
        addLit("abort_req_in_req", 2, 32'h1);
        postLits();
        @(posedge clk);
        #1;
        dmem_gnt_i = 1'b0;
        valid_i = 1'b0; mem_read_c_i = 1'b0;
        addLit("resp_stall", 3, 32'h1);
        postLits();
        rst_n = 1'b0;
        #1;
        addLit("abort_req", 2, 32'h0);
        addLit("abort_stall", 3, 32'h0);
        addLit("abort_rdata", 0, 32'h0);
        postLits();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        dmem_rvalid_i = 1'b0;
        addLit("late_rvalid_rdata", 0, 32'h0);
        addLit("late_rvalid_stall", 3, 32'h0);
        postLits();

        checkEn = 1'b1;
        expRd   = 32'h0;

        // SW 0x100
        applyStimulus(1, 0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 32'h0);
        addLit("sw_be", 8, 32'hF);
        addLit("sw_addr", 10, 32'h100);
        addLit("sw_wdata", 9, 32'hDEAD_BEEF);
        addLit("sw_stall_cycles", 12, 32'(stallBase + 2));
        postLits();

        // SB 0x203
        applyStimulus(1, 0, 1, 3'b000, 32'h203, 32'h0000_00A5, 0, 0, 0, 32'h0);
        addLit("sb_be", 8, 32'h8);
        addLit("sb_wdata", 9, 32'hA5A5_A5A5);
        addLit("sb_addr", 10, 32'h200);
        addLit("sb_we", 11, 32'h1);
        postLits();

        // LB / LBU / LH
        applyStimulus(1, 1, 0, 3'b000, 32'h301, 32'h0, 0, 0, 1, 32'h0000_80FF);
        addLit("lb_data", 0, 32'hFFFF_FF80);
        postLits();
        applyStimulus(1, 1, 0, 3'b100, 32'h301, 32'h0, 0, 0, 1, 32'h0000_80FF);
        addLit("lbu_data", 0, 32'h0000_0080);
        postLits();
        applyStimulus(1, 1, 0, 3'b001, 32'h302, 32'h0, 0, 0, 1, 32'h8001_0000);
        addLit("lh_data", 0, 32'hFFFF_8001);
        postLits();

        // LW with three grant wait cycles and one data wait cycle.
        applyStimulus(1, 1, 0, 3'b010, 32'h500, 32'h0, 3, 1, 1, 32'h1234_5678);
        addLit("lw_slow_data", 0, 32'h1234_5678);
        addLit("lw_slow_stall_cycles", 12, 32'(stallBase + 7));
        addLit("lw_slow_addr", 10, 32'h500);
        postLits();

        // Misaligned LW 0x102
        applyStimulus(1, 1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 0, 32'h0);
        addLit("mis_flag", 1, 32'h1);
        addLit("mis_req", 2, 32'h0);
        addLit("mis_stall", 3, 32'h0);
        addLit("mis_rdata", 0, 32'h1234_5678);
        postLits();

        // Randomized instruction stream.
        for (int t = 0; t < 250; t++) begin
            logic        v, rd, wr;
            logic [2:0]  f3;
            logic [31:0] a;
            int          kind;
            v    = ($urandom_range(0, 7) != 0);
            kind = $urandom_range(0, 4);
            rd   = (kind == 1) || (kind == 3) || (kind == 4);
            wr   = (kind == 2) || (kind == 3);
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom & 32'h0000_FFFF;
            applyStimulus(v, rd, wr, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 0, 32'h0);
        end

        @(posedge clk);
        #1;
        setIdleInputs();
        checkEn = 1'b0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
